// File: rtl/blackjack_round_ctrl.sv
// -----------------------------------------------------------------------------
// blackjack_round_ctrl
//
// Round sequencer for the blackjack game. Owns the shared card source through a
// request/valid handshake, deals player/dealer/player/dealer, runs the player's
// hit/stand turn and the dealer's automatic draws, then compares the hands.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   new_round  in   one-cycle pulse, starts a round from IDLE or RESULT
//   hit        in   one-cycle pulse, player requests a card (PLAYER only)
//   stand      in   one-cycle pulse, player ends the turn (PLAYER only)
//   card_req   out  request to the card source, held until card_valid
//   card_valid in   card source has a card on card_val
//   card_val   in   card rank, 1 = ace, 2-10 pip/face (0 and 11-15 count 10)
//   phand      out  player best total
//   dhand      out  dealer best total
//   busy       out  round in progress (not IDLE / RESULT)
//   result     out  00 none, 01 player win, 10 player lose, 11 push
//   state_out  out  current state code for the debug LEDs
// -----------------------------------------------------------------------------
module blackjack_round_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int BJ_LIMIT     = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_round,
  input  logic       hit,
  input  logic       stand,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_val,
  output logic [4:0] phand,
  output logic [4:0] dhand,
  output logic       busy,
  output logic [1:0] result,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_DEAL   = 3'b001,
    S_PLAYER = 3'b010,
    S_PDRAW  = 3'b011,
    S_DEALER = 3'b100,
    S_DDRAW  = 3'b101,
    S_RESULT = 3'b110
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_WIN  = 2'b01;
  localparam logic [1:0] RES_LOSE = 2'b10;
  localparam logic [1:0] RES_PUSH = 2'b11;

  localparam logic [4:0] STAND_T = 5'(DEALER_STAND);
  localparam logic [4:0] LIMIT_T = 5'(BJ_LIMIT);

  state_t     state;
  logic [4:0] p_hard, d_hard;
  logic       p_ace, d_ace;
  logic [1:0] deal_cnt;

  logic       handshake;
  logic [4:0] card_pts;
  logic       card_is_ace;
  logic       to_player, to_dealer;
  logic [4:0] p_hard_nx, d_hard_nx;
  logic       p_ace_nx, d_ace_nx;
  logic [4:0] p_best_nx, d_best_nx;

  // An ace counts 11 instead of 1 whenever that does not push the hand over 21.
  function automatic logic [4:0] best_of(input logic [4:0] hard, input logic ace);
    return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  // Player is never bust on entry to the compare; a player bust ends in PDRAW.
  function automatic logic [1:0] compare(input logic [4:0] p, input logic [4:0] d);
    if (d > LIMIT_T)  return RES_WIN;
    else if (p > d)   return RES_WIN;
    else if (p < d)   return RES_LOSE;
    else              return RES_PUSH;
  endfunction

  // card_req is only ever raised in a draw state, so a handshake always
  // belongs to the current draw step and a stray card_valid is ignored.
  assign handshake   = card_req && card_valid;
  assign card_pts    = (card_val == 4'd0 || card_val > 4'd10) ? 5'd10 : {1'b0, card_val};
  assign card_is_ace = (card_val == 4'd1);

  // Deal order is player, dealer, player, dealer: even counts go to the player.
  assign to_player = handshake && (state == S_PDRAW || (state == S_DEAL && !deal_cnt[0]));
  assign to_dealer = handshake && (state == S_DDRAW || (state == S_DEAL &&  deal_cnt[0]));

  // Hands after the card accepted this cycle, so the FSM can decide on the
  // new totals in the same cycle the card is sampled.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    p_hard_nx = p_hard;
    p_ace_nx  = p_ace;
    d_hard_nx = d_hard;
    d_ace_nx  = d_ace;
    if (to_player) begin
      p_hard_nx = p_hard + card_pts;
      p_ace_nx  = p_ace | card_is_ace;
    end
    if (to_dealer) begin
      d_hard_nx = d_hard + card_pts;
      d_ace_nx  = d_ace | card_is_ace;
    end
    p_best_nx = best_of(p_hard_nx, p_ace_nx);
    d_best_nx = best_of(d_hard_nx, d_ace_nx);
  end

  assign busy      = (state != S_IDLE) && (state != S_RESULT);
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values; blocking here would create ordering races.
      state    <= S_IDLE;
      card_req <= 1'b0;
      deal_cnt <= 2'd0;
      p_hard   <= 5'd0;
      p_ace    <= 1'b0;
      d_hard   <= 5'd0;
      d_ace    <= 1'b0;
      phand    <= 5'd0;
      dhand    <= 5'd0;
      result   <= RES_NONE;
    end else begin
      p_hard <= p_hard_nx;
      p_ace  <= p_ace_nx;
      d_hard <= d_hard_nx;
      d_ace  <= d_ace_nx;
      phand  <= p_best_nx;
      dhand  <= d_best_nx;

      case (state)
        S_IDLE, S_RESULT: begin
          if (new_round) begin
            state    <= S_DEAL;
            deal_cnt <= 2'd0;
            p_hard   <= 5'd0;
            p_ace    <= 1'b0;
            d_hard   <= 5'd0;
            d_ace    <= 1'b0;
            phand    <= 5'd0;
            dhand    <= 5'd0;
            result   <= RES_NONE;
          end
        end

        S_DEAL: begin
          if (handshake) begin
            // Dropping card_req for a cycle keeps one valid cycle from
            // feeding two consecutive deal cards.
            card_req <= 1'b0;
            deal_cnt <= deal_cnt + 2'd1;
            if (deal_cnt == 2'd3)
              state <= (p_best_nx == LIMIT_T) ? S_DEALER : S_PLAYER;
          end else if (!card_req) begin
            card_req <= 1'b1;
          end
        end

        S_PLAYER: begin
          if (stand)    state <= S_DEALER;
          else if (hit) state <= S_PDRAW;
        end

        S_PDRAW: begin
          if (handshake) begin
            card_req <= 1'b0;
            if (p_best_nx > LIMIT_T) begin
              state  <= S_RESULT;
              result <= RES_LOSE;
            end else if (p_best_nx == LIMIT_T) begin
              state <= S_DEALER;
            end else begin
              state <= S_PLAYER;
            end
          end else if (!card_req) begin
            card_req <= 1'b1;
          end
        end

        S_DEALER: begin
          if (dhand < STAND_T) begin
            state <= S_DDRAW;
          end else begin
            state  <= S_RESULT;
            result <= compare(phand, dhand);
          end
        end

        S_DDRAW: begin
          if (handshake) begin
            card_req <= 1'b0;
            state    <= S_DEALER;
          end else if (!card_req) begin
            card_req <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          card_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_blackjack_round_ctrl
//
// Bench for blackjack_round_ctrl. A card-source process serves cards from a
// deck queue with configurable delays, spurious and sticky valids. Each round
// is predicted by a plain-arithmetic blackjack model over the same deck and
// compared against the controller's hands, result and card usage.
// -----------------------------------------------------------------------------
module tb_blackjack_round_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DEAL   = 3'd1;
  localparam logic [2:0] ST_PLAYER = 3'd2;
  localparam logic [2:0] ST_PDRAW  = 3'd3;
  localparam logic [2:0] ST_DDRAW  = 3'd5;
  localparam logic [2:0] ST_RESULT = 3'd6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_round = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_val = 4'd0;
  logic       card_req;
  logic [4:0] phand, dhand;
  logic       busy;
  logic [1:0] result;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  blackjack_round_ctrl #(.DEALER_STAND(17), .BJ_LIMIT(21)) dut (
    .clk       (clk),
    .reset     (reset),
    .new_round (new_round),
    .hit       (hit),
    .stand     (stand),
    .card_req  (card_req),
    .card_valid(card_valid),
    .card_val  (card_val),
    .phand     (phand),
    .dhand     (dhand),
    .busy      (busy),
    .result    (result),
    .state_out (state_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Card source configuration and bookkeeping.
  int deck[$];
  int delays[$];
  int max_delay = 0;
  bit spur_en   = 1'b0;
  bit sticky    = 1'b0;
  int served    = 0;

  // Round deck and model predictions.
  int cards[32];
  int ncards;
  int exp_ph, exp_dh, exp_res, exp_used, exp_hits, exp_deal_p, exp_deal_d;
  bit exp_stand;

  // ---------------------------------------------------------------------------
  // Card source: decides card_valid at each falling edge for the next rising
  // edge. A card is consumed only when it was presented while card_req was
  // high at that rising edge and reset was low.
  // ---------------------------------------------------------------------------
  initial begin : card_source
    bit req_prev, rst_prev, consumed;
    int delay_left;
    req_prev   = 1'b0;
    rst_prev   = 1'b1;
    delay_left = -1;
    forever begin
      @(negedge clk);
      consumed = card_valid && req_prev && !rst_prev;
      if (consumed) begin
        served++;
        if (deck.size() > 0) void'(deck.pop_front());
        delay_left = -1;
      end
      req_prev = card_req;
      rst_prev = reset;
      if (reset || !card_req) begin
        delay_left = -1;
        if (sticky && deck.size() > 0) begin
          card_valid = 1'b1;
          card_val   = 4'(deck[0]);
        end else if (spur_en && $urandom_range(0, 2) == 0) begin
          card_valid = 1'b1;
          card_val   = 4'($urandom_range(0, 15));
        end else begin
          card_valid = 1'b0;
          card_val   = 4'($urandom_range(0, 15));
        end
      end else begin
        if (delay_left < 0) begin
          if (delays.size() > 0) delay_left = delays.pop_front();
          else                   delay_left = int'($urandom_range(0, max_delay));
        end
        if (delay_left == 0 && deck.size() > 0) begin
          card_valid = 1'b1;
          card_val   = 4'(deck[0]);
        end else begin
          card_valid = 1'b0;
          card_val   = 4'($urandom_range(0, 15));
          if (delay_left > 0) delay_left--;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model: blackjack rules in plain integers.
  // ---------------------------------------------------------------------------
  function automatic int pts(input int v);
    return (v == 0 || v > 10) ? 10 : v;
  endfunction

  // One ace may count as 11 if the hand stays at or under 21.
  function automatic int best(input int hard, input bit ace);
    return (ace && hard + 10 <= 21) ? hard + 10 : hard;
  endfunction

  // Player hits while below thr (and below 21), stands otherwise.
  task automatic model_round(input int thr);
    int ph, dh, k;
    bit pa, da, bust;
    ph = pts(cards[0]) + pts(cards[2]);
    pa = (cards[0] == 1) || (cards[2] == 1);
    dh = pts(cards[1]) + pts(cards[3]);
    da = (cards[1] == 1) || (cards[3] == 1);
    k  = 4;
    exp_deal_p = best(ph, pa);
    exp_deal_d = best(dh, da);
    exp_hits   = 0;
    exp_stand  = 1'b0;
    bust       = 1'b0;
    if (best(ph, pa) != 21) begin
      while (best(ph, pa) < thr && best(ph, pa) < 21) begin
        ph += pts(cards[k]);
        pa |= (cards[k] == 1);
        k++;
        exp_hits++;
      end
      if (best(ph, pa) > 21)      bust = 1'b1;
      else if (best(ph, pa) < 21) exp_stand = 1'b1;
    end
    if (!bust) begin
      while (best(dh, da) < 17) begin
        dh += pts(cards[k]);
        da |= (cards[k] == 1);
        k++;
      end
    end
    exp_ph   = best(ph, pa);
    exp_dh   = best(dh, da);
    exp_used = k;
    if (bust)                exp_res = 2;
    else if (exp_dh > 21)    exp_res = 1;
    else if (exp_ph > exp_dh) exp_res = 1;
    else if (exp_ph < exp_dh) exp_res = 2;
    else                     exp_res = 3;
  endtask

  task automatic load8(input int c0, c1, c2, c3, c4, c5, c6, c7);
    for (int i = 0; i < 32; i++) cards[i] = 10;
    cards[0] = c0; cards[1] = c1; cards[2] = c2; cards[3] = c3;
    cards[4] = c4; cards[5] = c5; cards[6] = c6; cards[7] = c7;
    ncards = 8;
  endtask

  // Called and returns on a falling edge.
  task automatic wait_state(input logic [2:0] code, input int budget, input string what);
    int i;
    i = 0;
    while (state_out !== code && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (state_out !== code) begin
      n_bad++;
      $display("FAIL %s: state_out=%0d required %0d within %0d cycles", what, state_out, code, budget);
    end
  endtask

  // Plays one round from IDLE or RESULT using the model's decisions.
  task automatic run_round(input int thr, input bit both, input bit stray, input string tag);
    bit late_req;
    deck.delete();
    for (int i = 0; i < ncards; i++) deck.push_back(cards[i]);
    served = 0;
    model_round(thr);

    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    if (stray) begin
      // Lands in DEAL and must be ignored.
      @(negedge clk);
      new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
    end

    if (exp_hits > 0 || exp_stand) begin
      wait_state(ST_PLAYER, 200, {tag, " reach_player"});
      n_cmp++;
      if (phand !== 5'(exp_deal_p) || dhand !== 5'(exp_deal_d) || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s deal_hands: phand=%0d dhand=%0d busy=%0b required %0d %0d 1",
                 tag, phand, dhand, busy, exp_deal_p, exp_deal_d);
      end
    end

    for (int h = 0; h < exp_hits; h++) begin
      wait_state(ST_PLAYER, 200, {tag, " before_hit"});
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      if (stray) begin
        // Sampled while in PDRAW and must be dropped.
        stand = 1'b1;
        @(negedge clk);
        stand = 1'b0;
      end
    end

    if (exp_stand) begin
      wait_state(ST_PLAYER, 200, {tag, " before_stand"});
      hit   = both;
      stand = 1'b1;
      @(negedge clk);
      hit   = 1'b0;
      stand = 1'b0;
    end

    wait_state(ST_RESULT, 400, {tag, " reach_result"});
    n_cmp++;
    if (phand !== 5'(exp_ph)) begin
      n_bad++;
      $display("FAIL %s phand: got %0d required %0d", tag, phand, exp_ph);
    end
    n_cmp++;
    if (dhand !== 5'(exp_dh)) begin
      n_bad++;
      $display("FAIL %s dhand: got %0d required %0d", tag, dhand, exp_dh);
    end
    n_cmp++;
    if (result !== 2'(exp_res) || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s result: got %0d busy=%0b required %0d busy=0", tag, result, busy, exp_res);
    end
    late_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (card_req !== 1'b0) late_req = 1'b1;
    end
    n_cmp++;
    if (served != exp_used || late_req) begin
      n_bad++;
      $display("FAIL %s cards_used: got %0d late_req=%0b required %0d late_req=0",
               tag, served, late_req, exp_used);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (state_out !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d required 0", state_out); end
    n_cmp++;
    if (card_req !== 1'b0) begin n_bad++; $display("FAIL reset_card_req: got %0b required 0", card_req); end
    n_cmp++;
    if (phand !== 5'd0 || dhand !== 5'd0) begin
      n_bad++; $display("FAIL reset_hands: phand=%0d dhand=%0d required 0 0", phand, dhand);
    end
    n_cmp++;
    if (result !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_result: result=%0d busy=%0b required 0 0", result, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    // hit/stand in IDLE do nothing.
    hit = 1'b1;
    @(negedge clk);
    hit   = 1'b0;
    stand = 1'b1;
    @(negedge clk);
    stand = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state_out !== ST_IDLE || card_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ignore: state=%0d card_req=%0b required 0 0", state_out, card_req);
    end
  endtask

  task automatic test_stand_win();
    load8(10, 7, 9, 8, 3, 10, 10, 10);
    run_round(0, 1'b0, 1'b0, "stand_win");
  endtask

  task automatic test_natural_push();
    load8(1, 10, 10, 6, 5, 10, 10, 10);
    run_round(0, 1'b0, 1'b0, "natural_push");
  endtask

  task automatic test_player_bust();
    load8(10, 9, 6, 8, 8, 10, 10, 10);
    run_round(17, 1'b0, 1'b0, "player_bust");
  endtask

  task automatic test_dealer_soft17();
    load8(10, 1, 8, 6, 10, 10, 10, 10);
    run_round(0, 1'b0, 1'b0, "dealer_soft17");
  endtask

  task automatic test_handshake_stress();
    delays.delete();
    delays = '{0, 1, 5, 0, 1, 5, 0, 1};
    spur_en = 1'b1;
    load8(13, 5, 2, 9, 1, 4, 0, 10);
    run_round(14, 1'b0, 1'b1, "handshake_stress");
    spur_en = 1'b0;
    sticky  = 1'b1;
    delays  = '{1, 0, 5, 0, 2, 0};
    load8(13, 5, 2, 9, 1, 4, 0, 10);
    run_round(14, 1'b0, 1'b0, "sticky_valid");
    sticky = 1'b0;
    delays.delete();
  endtask

  task automatic test_hit_stand_same();
    load8(10, 7, 9, 8, 3, 10, 10, 10);
    run_round(0, 1'b1, 1'b0, "hit_stand_same");
  endtask

  task automatic test_reset_mid_ddraw();
    load8(10, 7, 9, 8, 0, 0, 0, 0);
    ncards = 4;
    deck.delete();
    for (int i = 0; i < ncards; i++) deck.push_back(cards[i]);
    served = 0;
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    wait_state(ST_PLAYER, 200, "mid_ddraw reach_player");
    stand = 1'b1;
    @(negedge clk);
    stand = 1'b0;
    wait_state(ST_DDRAW, 50, "mid_ddraw reach_ddraw");
    repeat (2) @(negedge clk);
    n_cmp++;
    if (card_req !== 1'b1) begin n_bad++; $display("FAIL mid_ddraw req_high: got %0b required 1", card_req); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (card_req !== 1'b0 || state_out !== ST_IDLE) begin
      n_bad++;
      $display("FAIL mid_ddraw reset: card_req=%0b state=%0d required 0 0", card_req, state_out);
    end
    n_cmp++;
    if (phand !== 5'd0 || dhand !== 5'd0 || result !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_ddraw clear: phand=%0d dhand=%0d result=%0d busy=%0b required 0 0 0 0",
               phand, dhand, result, busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_rounds();
    max_delay = 3;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 32; i++) cards[i] = int'($urandom_range(0, 15));
      ncards  = 32;
      spur_en = ($urandom_range(0, 1) == 1);
      sticky  = ($urandom_range(0, 3) == 0);
      run_round(int'($urandom_range(12, 21)), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), $sformatf("random_%0d", r));
    end
    spur_en   = 1'b0;
    sticky    = 1'b0;
    max_delay = 0;
  endtask

  initial begin : main
    test_reset();
    test_stand_win();
    test_natural_push();
    test_player_bust();
    test_dealer_soft17();
    test_handshake_stress();
    test_hit_stand_same();
    test_reset_mid_ddraw();
    test_random_rounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
